// File: rtl/jesd_rx_pkg.sv
// rtl/jesd_rx_pkg.sv - shared types and helpers for the JESD204B RX sync logic
// Purpose: SYNC~ state encoding plus elaboration-time arithmetic helpers.
package jesd_rx_pkg;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_WAIT_CGS = 2'd1,
        ST_DATA     = 2'd2,
        ST_ERR      = 2'd3
    } sync_state_e;

    // Integer ceiling division, used for frame-to-clock conversions.
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/jesd_sync_n_gen.sv
// rtl/jesd_sync_n_gen.sv - JESD204B RX SYNC~ driver
// Purpose: holds SYNC~ low until all enabled lanes achieve CGS, releases it,
//          re-asserts it for resync requests or as exact-width error pulses.
// Ports:
//   clk_i           character clock
//   rst_ni          asynchronous active-low reset
//   enable_i        0 keeps the link in sync request
//   lane_en_i       lane mask, disabled lanes ignored
//   lane_cgs_done_i per-lane CGS achieved
//   err_report_i    1-cycle error report pulse
//   resync_req_i    1-cycle resync request pulse
//   sync_n_o        SYNC~ to the transmitter
//   link_up_o       link in data or error-pulse phase
//   sync_release_o  1-cycle pulse on the SYNC~ release
//   state_o         current FSM state
//   err_pulse_cnt_o saturating count of error pulses emitted
module jesd_sync_n_gen
    import jesd_rx_pkg::*;
#(
    parameter int NUM_LANES      = 4,
    parameter int F              = 2,
    parameter int OCTETS_PER_CLK = 4,
    parameter int ERR_CNT_W      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic [NUM_LANES-1:0] lane_en_i,
    input  logic [NUM_LANES-1:0] lane_cgs_done_i,
    input  logic                 err_report_i,
    input  logic                 resync_req_i,
    output logic                 sync_n_o,
    output logic                 link_up_o,
    output logic                 sync_release_o,
    output logic [1:0]           state_o,
    output logic [ERR_CNT_W-1:0] err_pulse_cnt_o
);

    localparam int ERR_CYCLES    = max_int(ceil_div(2 * F, OCTETS_PER_CLK), 1);
    localparam int RESYNC_CYCLES = max_int(ceil_div(5 * F + 9, OCTETS_PER_CLK), 1);
    localparam int CNT_W         = $clog2(max_int(RESYNC_CYCLES, ERR_CYCLES) + 1);

    // The counter holds the number of cycles already completed in the current
    // state, so the final cycle is the one where it equals the length minus one.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESYNC_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERR_LAST  = CNT_W'(ERR_CYCLES - 1);

    sync_state_e      state;
    logic [CNT_W-1:0] dur_cnt;
    logic             gap;
    logic             pending;

    logic all_cgs;
    logic drop_link;
    logic hold_last;
    logic err_last;

    assign all_cgs   = (&(lane_cgs_done_i | ~lane_en_i)) && (lane_en_i != '0);
    // Any of these takes the link down, and they outrank error reporting.
    assign drop_link = resync_req_i || !all_cgs || !enable_i;
    assign hold_last = (dur_cnt >= HOLD_LAST);
    assign err_last  = (dur_cnt >= ERR_LAST);

    assign state_o = state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= ST_HOLD;
            dur_cnt         <= '0;
            gap             <= 1'b0;
            pending         <= 1'b0;
            sync_n_o        <= 1'b0;
            link_up_o       <= 1'b0;
            sync_release_o  <= 1'b0;
            err_pulse_cnt_o <= '0;
        end else begin
            sync_release_o <= 1'b0;
            case (state)
                ST_HOLD: begin
                    if (resync_req_i) begin
                        dur_cnt <= '0;
                    end else if (hold_last) begin
                        // Hold satisfied; wait here for enable if it is low.
                        if (enable_i) begin
                            state   <= ST_WAIT_CGS;
                            dur_cnt <= '0;
                        end
                    end else begin
                        dur_cnt <= dur_cnt + 1'b1;
                    end
                end

                ST_WAIT_CGS: begin
                    if (all_cgs && enable_i) begin
                        state          <= ST_DATA;
                        sync_n_o       <= 1'b1;
                        link_up_o      <= 1'b1;
                        sync_release_o <= 1'b1;
                        gap            <= 1'b0;
                    end
                end

                ST_DATA: begin
                    if (drop_link) begin
                        state     <= ST_HOLD;
                        dur_cnt   <= '0;
                        gap       <= 1'b0;
                        pending   <= 1'b0;
                        sync_n_o  <= 1'b0;
                        link_up_o <= 1'b0;
                    end else if ((err_report_i || pending) && !gap) begin
                        // A new report arriving together with a pending one
                        // is coalesced into this single pulse.
                        state    <= ST_ERR;
                        dur_cnt  <= '0;
                        pending  <= 1'b0;
                        sync_n_o <= 1'b0;
                        if (!(&err_pulse_cnt_o)) begin
                            err_pulse_cnt_o <= err_pulse_cnt_o + 1'b1;
                        end
                    end else begin
                        if (err_report_i) begin
                            pending <= 1'b1;
                        end
                        gap <= 1'b0;
                    end
                end

                ST_ERR: begin
                    if (drop_link) begin
                        state     <= ST_HOLD;
                        dur_cnt   <= '0;
                        gap       <= 1'b0;
                        pending   <= 1'b0;
                        sync_n_o  <= 1'b0;
                        link_up_o <= 1'b0;
                    end else begin
                        if (err_report_i) begin
                            pending <= 1'b1;
                        end
                        if (err_last) begin
                            // The first data cycle after a pulse is a forced
                            // high gap so the TX sees two distinct edges.
                            state    <= ST_DATA;
                            dur_cnt  <= '0;
                            gap      <= 1'b1;
                            sync_n_o <= 1'b1;
                        end else begin
                            dur_cnt <= dur_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_HOLD;
                end
            endcase
        end
    end

endmodule
